// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: stage indices, timing field types
// and default multiply/divide unit latencies.
package id_hazard_ctrl_pkg;

  localparam int unsigned STG_GRF = 0;
  localparam int unsigned STG_E   = 1;
  localparam int unsigned STG_M   = 2;
  localparam int unsigned STG_W   = 3;

  localparam int unsigned T_W_DEF         = 2;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef logic [T_W_DEF-1:0] tuse_t;
  typedef logic [T_W_DEF-1:0] tnew_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decoder-summary / hazard-result bundle between the ID stage and the hazard controller.
interface id_hazard_ctrl_if
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned T_W    = T_W_DEF,
  parameter int unsigned SEL_W  = 2
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic [T_W-1:0]    id_tuse_rs;
  logic [T_W-1:0]    id_tuse_rt;
  logic [ADDR_W-1:0] id_dst;
  logic [T_W-1:0]    id_tnew;
  logic              id_md_use;
  logic              md_start;
  logic              md_is_div;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_tuse_rs, id_tuse_rt,
    output id_dst, id_tnew, id_md_use, md_start, md_is_div,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_tuse_rs, id_tuse_rt,
    input  id_dst, id_tnew, id_md_use, md_start, md_is_div,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

endinterface

// File: rtl/id_md_busy_counter.sv
// Multiply/divide unit busy counter: loads the operation latency on start (restarting if
// already busy) and counts down to zero.
module id_md_busy_counter
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_start) begin
      w_cnt_nxt = i_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: scoreboard of in-flight register writes per post-ID stage,
// producing the ID stall request and the rs/rt forwarding selects.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned T_W         = T_W_DEF,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned SEL_W       = $clog2(STAGES + 1)
) (
  input logic            clk,
  input logic            rst_n,
  id_hazard_ctrl_if.slave hz
);

  logic              w_valid [STAGES:1];
  logic [ADDR_W-1:0] w_dst   [STAGES:1];
  logic [T_W-1:0]    w_tnew  [STAGES:1];
  logic [STAGES:1]   w_hit_rs;
  logic [STAGES:1]   w_hit_rt;

  logic             w_stall;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic [SEL_W-1:0] w_fwd_rs;
  logic [SEL_W-1:0] w_fwd_rt;
  logic             w_md_busy;

  for (genvar k = STG_E; k <= STAGES; k++) begin : g_stage
    logic              r_valid;
    logic [ADDR_W-1:0] r_dst;
    logic [T_W-1:0]    r_tnew;
    logic              w_nxt_valid;
    logic [ADDR_W-1:0] w_nxt_dst;
    logic [T_W-1:0]    w_nxt_tnew;

    if (k == STG_E) begin : g_head
      // A stalled ID instruction stays put, so E receives a bubble.
      assign w_nxt_valid = hz.id_valid & ~w_stall;
      assign w_nxt_dst   = hz.id_dst;
      assign w_nxt_tnew  = hz.id_tnew;
    end else begin : g_tail
      assign w_nxt_valid = w_valid[k-1];
      assign w_nxt_dst   = w_dst[k-1];
      assign w_nxt_tnew  = (w_tnew[k-1] == '0) ? '0 : w_tnew[k-1] - T_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_dst   <= '0;
        r_tnew  <= '0;
      end else begin
        r_valid <= w_nxt_valid;
        r_dst   <= w_nxt_dst;
        r_tnew  <= w_nxt_tnew;
      end
    end

    assign w_valid[k]  = r_valid;
    assign w_dst[k]    = r_dst;
    assign w_tnew[k]   = r_tnew;
    // A nonzero source address excludes dst==0 entries from matching.
    assign w_hit_rs[k] = r_valid & hz.id_rs_use & (hz.id_rs != '0) & (r_dst == hz.id_rs);
    assign w_hit_rt[k] = r_valid & hz.id_rt_use & (hz.id_rt != '0) & (r_dst == hz.id_rt);
  end

  // Walk from the deepest stage up so the nearest matching producer is the one kept.
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    w_fwd_rs   = '0;
    w_fwd_rt   = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (w_hit_rs[k]) begin
        w_stall_rs = (w_tnew[k] > hz.id_tuse_rs);
        w_fwd_rs   = (w_tnew[k] == '0) ? SEL_W'(k) : '0;
      end
      if (w_hit_rt[k]) begin
        w_stall_rt = (w_tnew[k] > hz.id_tuse_rt);
        w_fwd_rt   = (w_tnew[k] == '0) ? SEL_W'(k) : '0;
      end
    end
  end

  id_md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (hz.md_start),
    .i_is_div(hz.md_is_div),
    .o_busy  (w_md_busy)
  );

  // rst_n gating keeps a same-cycle md_start from raising stall while in reset.
  assign w_stall = rst_n & hz.id_valid &
                   (w_stall_rs | w_stall_rt | (hz.id_md_use & (w_md_busy | hz.md_start)));

  assign hz.stall      = w_stall;
  assign hz.fwd_rs_sel = w_fwd_rs;
  assign hz.fwd_rt_sel = w_fwd_rt;
  assign hz.md_busy    = w_md_busy;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expected outputs are queued as each step is driven and
// popped for comparison half a cycle later.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int unsigned STAGES = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned T_W    = 2;
  localparam int unsigned SEL_W  = $clog2(STAGES + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.ADDR_W(ADDR_W), .T_W(T_W), .SEL_W(SEL_W)) hz ();

  id_hazard_ctrl #(
    .STAGES     (STAGES),
    .ADDR_W     (ADDR_W),
    .T_W        (T_W),
    .MULT_CYCLES(MULT_CYCLES_DEF),
    .DIV_CYCLES (DIV_CYCLES_DEF),
    .SEL_W      (SEL_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] frs;
    logic [SEL_W-1:0] frt;
    logic             busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic expect_out(input string tag, input logic s, input int frs, input int frt,
                            input logic b);
    exp_t e;
    e.stall = s;
    e.frs   = SEL_W'(frs);
    e.frt   = SEL_W'(frt);
    e.busy  = b;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
    end
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "stall", 8'(hz.stall), 8'(e.stall));
      cmp(t, "fwd_rs", 8'(hz.fwd_rs_sel), 8'(e.frs));
      cmp(t, "fwd_rt", 8'(hz.fwd_rt_sel), 8'(e.frt));
      cmp(t, "md_busy", 8'(hz.md_busy), 8'(e.busy));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_valid   = 1'b0;
    hz.id_rs      = '0;
    hz.id_rt      = '0;
    hz.id_rs_use  = 1'b0;
    hz.id_rt_use  = 1'b0;
    hz.id_tuse_rs = '0;
    hz.id_tuse_rt = '0;
    hz.id_dst     = '0;
    hz.id_tnew    = '0;
    hz.id_md_use  = 1'b0;
    hz.md_start   = 1'b0;
    hz.md_is_div  = 1'b0;
  endtask

  task automatic prod(input int dst, input int tnew);
    idle();
    hz.id_valid = 1'b1;
    hz.id_dst   = ADDR_W'(dst);
    hz.id_tnew  = T_W'(tnew);
  endtask

  task automatic rd_rs(input int rs, input int tuse);
    hz.id_valid   = 1'b1;
    hz.id_rs      = ADDR_W'(rs);
    hz.id_rs_use  = 1'b1;
    hz.id_tuse_rs = T_W'(tuse);
  endtask

  task automatic rd_rt(input int rt, input int tuse);
    hz.id_valid   = 1'b1;
    hz.id_rt      = ADDR_W'(rt);
    hz.id_rt_use  = 1'b1;
    hz.id_tuse_rt = T_W'(tuse);
  endtask

  task automatic flush();
    idle();
    repeat (3) begin
      expect_out("flush", 1'b0, 0, 0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #3;
    hz.id_valid  = 1'b1;
    hz.id_md_use = 1'b1;
    hz.md_start  = 1'b1;
    #1;
    expect_out("reset", 1'b0, 0, 0, 1'b0);
    check_now();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use: one stall, then no forward needed from M.
    prod(8, 2);
    expect_out("lu_lw", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 1); hz.id_dst = 5'd10; hz.id_tnew = 2'd1;
    expect_out("lu_stall", 1'b1, 0, 0, 1'b0); tick();
    expect_out("lu_go", 1'b0, 0, 0, 1'b0); tick();
    flush();

    // Load then branch: two stalls, then forward from W.
    prod(8, 2);
    expect_out("lb_lw", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 0);
    expect_out("lb_stall1", 1'b1, 0, 0, 1'b0); tick();
    expect_out("lb_stall2", 1'b1, 0, 0, 1'b0); tick();
    expect_out("lb_fwd", 1'b0, 3, 0, 1'b0); tick();
    flush();

    // ALU then branch on rt: one stall, then forward from M.
    prod(9, 1);
    expect_out("ab_alu", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rt(9, 0);
    expect_out("ab_stall", 1'b1, 0, 0, 1'b0); tick();
    expect_out("ab_fwd", 1'b0, 0, 2, 1'b0); tick();
    flush();

    // Register 0 never matches.
    prod(0, 2);
    expect_out("r0_prod", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(0, 0); rd_rt(0, 0);
    expect_out("r0_read", 1'b0, 0, 0, 1'b0); tick();
    flush();

    // Nearest producer wins even though a deeper one is ready.
    prod(8, 1);
    expect_out("pr_p1", 1'b0, 0, 0, 1'b0); tick();
    prod(8, 1);
    expect_out("pr_p2", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 1);
    expect_out("pr_near", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 0); rd_rt(8, 0);
    expect_out("pr_m_over_w", 1'b0, 2, 2, 1'b0); tick();
    flush();

    // mult: consumer stalls in the start cycle plus 5 busy cycles.
    idle(); hz.id_valid = 1'b1; hz.id_md_use = 1'b1; hz.md_start = 1'b1;
    expect_out("mul_start", 1'b1, 0, 0, 1'b0); tick();
    hz.md_start = 1'b0;
    repeat (MULT_CYCLES_DEF) begin
      expect_out("mul_busy", 1'b1, 0, 0, 1'b1); tick();
    end
    expect_out("mul_done", 1'b0, 0, 0, 1'b0); tick();
    flush();

    // div: 10 busy cycles.
    idle(); hz.id_valid = 1'b1; hz.id_md_use = 1'b1; hz.md_start = 1'b1; hz.md_is_div = 1'b1;
    expect_out("div_start", 1'b1, 0, 0, 1'b0); tick();
    hz.md_start = 1'b0;
    repeat (DIV_CYCLES_DEF) begin
      expect_out("div_busy", 1'b1, 0, 0, 1'b1); tick();
    end
    expect_out("div_done", 1'b0, 0, 0, 1'b0); tick();
    flush();

    // Restart while busy; an invalid ID slot never stalls.
    idle(); hz.id_md_use = 1'b1; hz.md_start = 1'b1;
    expect_out("rs_inval", 1'b0, 0, 0, 1'b0); tick();
    idle();
    expect_out("rs_busy", 1'b0, 0, 0, 1'b1); tick();
    hz.md_start = 1'b1; hz.md_is_div = 1'b1;
    expect_out("rs_restart", 1'b0, 0, 0, 1'b1); tick();
    idle();
    repeat (DIV_CYCLES_DEF) begin
      expect_out("rs_busy2", 1'b0, 0, 0, 1'b1); tick();
    end
    expect_out("rs_done", 1'b0, 0, 0, 1'b0); tick();
    flush();

    // Asynchronous reset during a load-use stall with a live forward and busy MDU.
    prod(7, 0);
    expect_out("ar_p7", 1'b0, 0, 0, 1'b0); tick();
    prod(8, 2); hz.md_start = 1'b1;
    expect_out("ar_lw", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 1); rd_rt(7, 0);
    @(negedge clk);
    expect_out("ar_pre", 1'b1, 0, 2, 1'b1);
    check_now();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("ar_drop", 1'b0, 0, 0, 1'b0);
    check_now();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(); rd_rs(3, 0); rd_rt(4, 0); hz.id_dst = 5'd5; hz.id_tnew = 2'd1;
    expect_out("ar_indep", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(8, 0); rd_rt(7, 0);
    expect_out("ar_empty", 1'b0, 0, 0, 1'b0); tick();
    idle(); rd_rs(5, 0);
    expect_out("ar_fwd5", 1'b0, 2, 0, 1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Decode-stage hazard controller for the five-stage MIPS pipeline; it sits beside the ID-stage decoder and consumes that decoder's per-instruction register-use summary. It keeps a scoreboard of in-flight register writes for every stage after ID, plus a busy counter for the multiply/divide unit. From these it produces the ID stall request and the ID-stage forwarding selects. Depth, register-address width and MDU latencies are parametrised.

## Interface
- STAGES, 3: tracked stages after ID (1=E, 2=M, 3=W)
- ADDR_W, 5: register address width
- T_W, 2: width of Tuse/Tnew fields
- MULT_CYCLES, 5: MDU busy cycles for mult/multu
- DIV_CYCLES, 10: MDU busy cycles for div/divu
- SEL_W, $clog2(STAGES+1): forward-select width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  ADDR_W  source register addresses
- id_rs_use, id_rt_use  in  1  the source is actually read
- id_tuse_rs, id_tuse_rt  in  T_W  cycles until the source value is needed (0 = needed in ID)
- id_dst  in  ADDR_W  destination register (0 = no write)
- id_tnew  in  T_W  cycles until the result exists, counted from E entry
- id_md_use  in  1  ID instruction accesses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- md_start  in  1  E stage starts an MDU operation this cycle
- md_is_div  in  1  qualifies md_start
- stall  out  1  freeze PC/IF-ID and inject a bubble into E
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = GRF, k = value from tracked stage k
- md_busy  out  1  MDU counter nonzero

## Operation
- Scoreboard has STAGES entries {valid, dst, tnew}. On each clock edge, entry k+1 takes entry k, with tnew decremented and saturating at 0.
- Entry 1 loads {id_valid & ~stall, id_dst, id_tnew}. During a stall it loads a bubble (valid=0).
- An entry whose dst is 0 never matches.
- Per used source s with nonzero address: the match is the lowest k with valid and dst==s. The nearest match wins even if a deeper entry is ready.
  - stall_s = match present and tnew_k > tuse_s.
  - fwd_s = k when the match has tnew_k==0, otherwise 0.
  - No match, unused source, or address 0: stall_s=0 and fwd_s=0.
- MDU counter:
  - md_start loads DIV_CYCLES if md_is_div, otherwise MULT_CYCLES. This also applies while the counter is busy (restart).
  - Otherwise the counter decrements to 0.
- stall = id_valid & (stall_rs | stall_rt | (id_md_use & (md_busy | md_start))).
- Reset: all entries invalid, counter 0. Therefore stall=0, fwd_*=0 and md_busy=0 while rst_n is low and immediately on its assertion, with no clock needed.

## Timing
- stall and fwd_* are combinational from the ID inputs and registered state, valid in the same cycle. The scoreboard and counter update on the rising edge.
- Load-use hazard (tnew 2, tuse 1): exactly 1 stall cycle.
- Load then a branch (tuse 0): 2 stall cycles, then fwd_sel=3.
- md_busy is high for exactly N cycles after the md_start edge. An MDU consumer in ID stalls in the md_start cycle plus N cycles.
- Simultaneous md_start and id_md_use: stall.
- Deasserting rst_n mid-stall drops stall asynchronously. The first edge after release starts from the empty state.
- Tnew never wraps below 0.

## Structure
- Shared package: stage index constants (STG_GRF=0, STG_E=1, STG_M=2, STG_W=3), tuse_t and tnew_t typedefs, and MDU latency defaults.
- Sub-module id_md_busy_counter: the MDU counter with load, decrement and busy flag.
- The scoreboard and match logic are a generate loop over STAGES inside the top module.

## Test plan
- Load-use: lw dst=8 tnew=2, then addu rs=8 tuse=1.
  - Required: stall=1 for 1 cycle, then stall=0 with fwd_rs_sel=0.
- Load then branch: lw dst=8 tnew=2, then beq rs=8 tuse=0.
  - Required: stall=1 for 2 cycles, then stall=0 with fwd_rs_sel=3.
- ALU then branch: addu dst=9 tnew=1, then beq rt=9 tuse=0.
  - Required: 1 stall cycle, then fwd_rt_sel=2.
- Register 0 and priority:
  - Any producer with dst=0 and a reader of $0 gives stall=0 and fwd=0.
  - Entry 1 {dst=8, tnew=1} with entry 2 {dst=8, tnew=0}, reader tuse=1: stall=0 and fwd_rs_sel=0.
- MDU: md_start with md_is_div=0, then mflo in ID (id_md_use=1).
  - Required: md_busy high for 5 cycles and stall high until md_busy falls.
  - Repeat with md_is_div=1: 10 cycles.
- Reset mid-stall: drop rst_n asynchronously during a load-use stall.
  - Required: stall, fwd_* and md_busy go to 0 immediately, and a following independent instruction sees no stall.
